// File: rtl/note_scroll_sequencer.sv
// note_scroll_sequencer: two-track scrolling note scheduler with per-pixel note-object enables.
// Latency: pixel enables 1 clk after pixel_x/pixel_y; note_done/overflow 1 clk after the cause.
// Backpressure: none; a push to a full track queue is dropped and flagged on overflow[t].
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   frame_tick              one-cycle pulse per frame; advances scroll / load / retire
//   note_wr, note_track,    push request into track queue (track 0 -> bit0 outputs)
//   note_pitch
//   pixel_x, pixel_y        current pixel being drawn
//   objetoNotasOn(2)        registered "pixel inside active note" for track 1 / track 2
//   full                    per-track queue full (combinational from occupancy)
//   overflow, note_done     registered one-cycle pulses per track
//   pause                   only when NOTE_PAUSE_EN is defined: freezes frame_tick effects

// Small generic FIFO: one write and one read port, occupancy counter.
// Latency: read data is the head entry, valid combinationally while non-empty.
// Backpressure: a push while full is ignored unless a pop frees the slot the same cycle.
module nss_fifo #(
  parameter int AW = 2,
  parameter int W  = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Two-track note scroller: queues pitches per track, moves the active note left each frame.
// Latency: objetoNotasOn/objetoNotasOn2 registered, 1 clk behind pixel_x/pixel_y.
// Backpressure: none; pushes to a full queue are dropped and pulse overflow[t].
module note_scroll_sequencer #(
  parameter int START_X  = 620,
  parameter int END_X    = 40,
  parameter int STEP     = 2,
  parameter int NOTE_W   = 16,
  parameter int NOTE_H   = 8,
  parameter int STAFF_Y0 = 200,
  parameter int PITCH_SP = 8,
  parameter int FIFO_AW  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       note_wr,
  input  logic       note_track,
  input  logic [2:0] note_pitch,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       objetoNotasOn,
  output logic       objetoNotasOn2,
  output logic [1:0] full,
  output logic [1:0] overflow,
  output logic [1:0] note_done
`ifdef NOTE_PAUSE_EN
  ,
  input  logic       pause
`endif
);
  // All geometry is evaluated in 11 bits so x+NOTE_W and y0+NOTE_H never wrap.
  localparam logic [10:0] START_X_C  = 11'(START_X);
  localparam logic [10:0] RET_TH_C   = 11'(END_X + STEP);
  localparam logic [10:0] STEP_C     = 11'(STEP);
  localparam logic [10:0] NOTE_W_C   = 11'(NOTE_W);
  localparam logic [10:0] NOTE_H_C   = 11'(NOTE_H);
  localparam logic [10:0] STAFF_Y0_C = 11'(STAFF_Y0);
  localparam logic [10:0] PITCH_SP_C = 11'(PITCH_SP);

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } trk_state_t;

  logic        tick;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [1:0]  done_c;
  logic [1:0]  hit;
  logic [10:0] px11;
  logic [10:0] py11;

`ifdef NOTE_PAUSE_EN
  assign tick = frame_tick && !pause;
`else
  assign tick = frame_tick;
`endif

  assign push[0] = note_wr && !note_track;
  assign push[1] = note_wr &&  note_track;
  assign px11    = {1'b0, pixel_x};
  assign py11    = {1'b0, pixel_y};

  for (genvar g = 0; g < 2; g++) begin : g_trk
    trk_state_t  st_q;
    trk_state_t  st_d;
    logic [9:0]  x_q;
    logic [9:0]  x_d;
    logic [2:0]  pitch_q;
    logic [2:0]  pitch_d;
    logic        pop_l;
    logic        done_l;
    logic [2:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [10:0] x11;
    logic [10:0] y0;
    logic        in_x;
    logic        in_y;

    nss_fifo #(
      .AW (FIFO_AW),
      .W  (3)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[g]),
      .pop     (pop_l),
      .din     (note_pitch),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q    <= IDLE;
        x_q     <= START_X_C[9:0];
        pitch_q <= '0;
      end else begin
        st_q    <= st_d;
        x_q     <= x_d;
        pitch_q <= pitch_d;
      end
    end

    // Position and pitch only move on a tick, so a note never shifts mid-frame.
    // The FIFO empty flag is the pre-push value, so a push landing with the tick
    // that finds the queue empty waits for the following tick.
    always_comb begin
      st_d    = st_q;
      x_d     = x_q;
      pitch_d = pitch_q;
      pop_l   = 1'b0;
      done_l  = 1'b0;
      case (st_q)
        IDLE: begin
          if (tick && !fifo_empty) begin
            pop_l   = 1'b1;
            pitch_d = fifo_dout;
            x_d     = START_X_C[9:0];
            st_d    = SCROLL;
          end
        end
        SCROLL: begin
          if (tick) begin
            if ({1'b0, x_q} >= RET_TH_C) begin
              x_d = x_q - STEP_C[9:0];
            end else begin
              done_l = 1'b1;
              if (!fifo_empty) begin
                pop_l   = 1'b1;
                pitch_d = fifo_dout;
                x_d     = START_X_C[9:0];
              end else begin
                st_d = IDLE;
              end
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end

    assign x11  = {1'b0, x_q};
    assign y0   = STAFF_Y0_C + 11'(pitch_q) * PITCH_SP_C;
    assign in_x = (px11 >= x11) && (px11 < x11 + NOTE_W_C);
    assign in_y = (py11 >= y0)  && (py11 < y0 + NOTE_H_C);

    assign hit[g]    = (st_q == SCROLL) && in_x && in_y;
    assign pop[g]    = pop_l;
    assign done_c[g] = done_l;
    assign full[g]   = fifo_full;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      objetoNotasOn  <= 1'b0;
      objetoNotasOn2 <= 1'b0;
      note_done      <= '0;
      overflow       <= '0;
    end else begin
      objetoNotasOn  <= hit[0];
      objetoNotasOn2 <= hit[1];
      note_done      <= done_c;
      // Dropped only if full and the same cycle does not pop a slot free.
      overflow       <= push & full & ~pop;
    end
  end
endmodule

// File: tb/tb_note_scroll_sequencer.sv
module tb_note_scroll_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       note_wr = 1'b0;
  logic       note_track = 1'b0;
  logic [2:0] note_pitch = '0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       pause = 1'b0;
  logic       on1;
  logic       on2;
  logic [1:0] full;
  logic [1:0] overflow;
  logic [1:0] note_done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [9:0] px;
    logic [9:0] py;
    logic       e1;
    logic       e2;
  } pix_vec_t;

  pix_vec_t vecs [8];

  note_scroll_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .note_wr        (note_wr),
    .note_track     (note_track),
    .note_pitch     (note_pitch),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .objetoNotasOn  (on1),
    .objetoNotasOn2 (on2),
    .full           (full),
    .overflow       (overflow),
    .note_done      (note_done)
`ifdef NOTE_PAUSE_EN
    ,
    .pause          (pause)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic trk, input logic [2:0] p);
    note_wr = 1'b1;
    note_track = trk;
    note_pitch = p;
    step();
    note_wr = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic e1, input logic e2);
    pixel_x = x;
    pixel_y = y;
    step();
    check({name, ".on1"}, 32'(on1), 32'(e1));
    check({name, ".on2"}, 32'(on2), 32'(e2));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int pulses;

    // Track 0 note at pitch 3: box x 620..635, y 224..231.
    vecs[0] = '{"in_tl",    10'd620, 10'd224, 1'b1, 1'b0};
    vecs[1] = '{"in_br",    10'd635, 10'd231, 1'b1, 1'b0};
    vecs[2] = '{"in_mid",   10'd627, 10'd228, 1'b1, 1'b0};
    vecs[3] = '{"right_out",10'd636, 10'd224, 1'b0, 1'b0};
    vecs[4] = '{"left_out", 10'd619, 10'd224, 1'b0, 1'b0};
    vecs[5] = '{"above",    10'd620, 10'd223, 1'b0, 1'b0};
    vecs[6] = '{"below",    10'd620, 10'd232, 1'b0, 1'b0};
    vecs[7] = '{"far",      10'd100, 10'd100, 1'b0, 1'b0};

    // Reset held while pushes and ticks toggle.
    pixel_x = 10'd620;
    pixel_y = 10'd200;
    for (int i = 0; i < 6; i++) begin
      note_wr = i[0];
      frame_tick = ~i[0];
      note_track = i[1];
      step();
    end
    note_wr = 1'b0;
    frame_tick = 1'b0;
    check("rst.on1", 32'(on1), 0);
    check("rst.on2", 32'(on2), 0);
    check("rst.note_done", 32'(note_done), 0);
    check("rst.overflow", 32'(overflow), 0);
    check("rst.full", 32'(full), 0);
    reset_n = 1'b1;
    step();
    tick();
    check("idle_tick.done", 32'(note_done), 0);
    pix("idle", 10'd620, 10'd200, 1'b0, 1'b0);

    // Load track 0, pitch 3, then table-driven pixel checks.
    push(1'b0, 3'd3);
    tick();
    for (int i = 0; i < 8; i++) begin
      pix(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].e1, vecs[i].e2);
    end

    // 290 decrement ticks take x from 620 to 40 with no retire.
    pulses = 0;
    for (int i = 0; i < 290; i++) begin
      tick();
      if (note_done != 2'b00) pulses++;
    end
    check("scroll.no_early_done", 32'(pulses), 0);
    pix("x40_left", 10'd40, 10'd224, 1'b1, 1'b0);
    pix("x40_right", 10'd55, 10'd231, 1'b1, 1'b0);
    pix("x40_outside", 10'd39, 10'd224, 1'b0, 1'b0);
    tick();
    check("retire.done", 32'(note_done), 32'h1);
    step();
    check("retire.done_clear", 32'(note_done), 0);
    pix("retired", 10'd40, 10'd224, 1'b0, 1'b0);

    // Queue full on track 1.
    push(1'b1, 3'd0);
    check("q1.full", 32'(full), 0);
    push(1'b1, 3'd1);
    push(1'b1, 3'd2);
    check("q3.full", 32'(full), 0);
    push(1'b1, 3'd3);
    check("q4.full", 32'(full), 32'h2);
    check("q4.overflow", 32'(overflow), 0);
    push(1'b1, 3'd4);
    check("q5.overflow", 32'(overflow), 32'h2);
    check("q5.full", 32'(full), 32'h2);
    step();
    check("q5.overflow_clear", 32'(overflow), 0);
    tick();
    check("q.load_full", 32'(full), 0);
    pix("trk2_p0", 10'd620, 10'd200, 1'b0, 1'b1);
    push(1'b1, 3'd5);
    check("q.refull", 32'(full), 32'h2);
    for (int i = 0; i < 290; i++) begin
      tick();
    end
    // Retire pops while a push lands on the full queue.
    note_wr = 1'b1;
    note_track = 1'b1;
    note_pitch = 3'd6;
    frame_tick = 1'b1;
    step();
    note_wr = 1'b0;
    frame_tick = 1'b0;
    check("pushpop.done", 32'(note_done), 32'h2);
    check("pushpop.overflow", 32'(overflow), 0);
    check("pushpop.full", 32'(full), 32'h2);
    pix("trk2_p1", 10'd620, 10'd208, 1'b0, 1'b1);

    // Push into an empty queue on the same cycle as a tick: loads one tick later.
    do_reset();
    note_wr = 1'b1;
    note_track = 1'b0;
    note_pitch = 3'd2;
    frame_tick = 1'b1;
    step();
    note_wr = 1'b0;
    frame_tick = 1'b0;
    pix("same_tick_noload", 10'd620, 10'd216, 1'b0, 1'b0);
    tick();
    pix("next_tick_load", 10'd620, 10'd216, 1'b1, 1'b0);

    // Overlap: both tracks pitch 0 on the same tick.
    do_reset();
    push(1'b0, 3'd0);
    push(1'b1, 3'd0);
    tick();
    pix("overlap", 10'd620, 10'd200, 1'b1, 1'b1);
    pix("overlap_out", 10'd636, 10'd200, 1'b0, 1'b0);

    // Reset mid-scroll at x=400 with two queued notes on track 0.
    push(1'b0, 3'd1);
    push(1'b0, 3'd2);
    for (int i = 0; i < 110; i++) begin
      tick();
    end
    pix("x400", 10'd400, 10'd200, 1'b1, 1'b1);
    reset_n = 1'b0;
    #2;
    check("midrst.on1", 32'(on1), 0);
    check("midrst.full", 32'(full), 0);
    step();
    reset_n = 1'b1;
    step();
    tick();
    check("midrst.done", 32'(note_done), 0);
    pix("midrst_x400", 10'd400, 10'd200, 1'b0, 1'b0);
    pix("midrst_start", 10'd620, 10'd200, 1'b0, 1'b0);
    pix("midrst_queued", 10'd620, 10'd208, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/note_scroll_sequencer.md
# note_scroll_sequencer

Schedules the scrolling notes drawn on the staff. Two independent note tracks each hold a small queue of pending pitches. On every frame the sequencer moves each track's active note left by a fixed step, and retires it at the left edge so the next queued note can load. Per pixel, it generates the two note-object enables consumed by the display colour multiplexer: `objetoNotasOn` and `objetoNotasOn2`.

## Interface
Parameters:
- `START_X`, 620: x of a newly loaded note (left edge of note box).
- `END_X`, 40: retire threshold.
- `STEP`, 2: pixels moved per frame.
- `NOTE_W`, 16: note box width.
- `NOTE_H`, 8: note box height.
- `STAFF_Y0`, 200: y of pitch 0 top edge.
- `PITCH_SP`, 8: vertical spacing per pitch step.
- `FIFO_AW`, 2: log2 of queue depth per track (depth 4).

Ports:
- `clk`  in  1: pixel/system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `frame_tick`  in  1: one-cycle pulse at start of vertical blanking.
- `note_wr`  in  1: push request, one cycle.
- `note_track`  in  1: target track for push (0 → track 1, 1 → track 2).
- `note_pitch`  in  3: staff position 0..7.
- `pixel_x`  in  10: current pixel column.
- `pixel_y`  in  10: current pixel row.
- `objetoNotasOn`  out  1: pixel inside track 1 active note.
- `objetoNotasOn2`  out  1: pixel inside track 2 active note.
- `full`  out  2: per-track queue full, bit0 = track 1.
- `overflow`  out  2: one-cycle pulse when a push is dropped.
- `note_done`  out  2: one-cycle pulse when a track retires its note.
- `pause`  in  1: present only with `NOTE_PAUSE_EN`.

## Operation
- Each track has a FIFO (depth 2^FIFO_AW, 3-bit entries), a 10-bit `x` register, a 3-bit `pitch` register and a two-state FSM: IDLE, SCROLL.
- IDLE:
  - On `frame_tick` with FIFO non-empty: pop into `pitch`, set `x`=START_X, go to SCROLL.
  - Otherwise stay in IDLE.
- SCROLL, on `frame_tick`:
  - If `x` ≥ END_X+STEP: `x` ← `x`−STEP.
  - Else retire: pulse `note_done[t]`. If the FIFO is non-empty, pop, set `x`=START_X and stay in SCROLL; otherwise go to IDLE.
- `x` and `pitch` change only on `frame_tick`, so no note moves mid-frame.
- Push:
  - Accepted when not full.
  - When full, the push is dropped and `overflow[t]` pulses.
  - A push and a pop on the same cycle to a full FIFO: the pop frees a slot and the push is accepted; occupancy is unchanged.
  - A push to an empty FIFO on the same cycle as a `frame_tick` in IDLE is not popped that tick; it loads on the next tick.
- `full[t]` is combinational from the occupancy counter (3 bits for depth 4).
- Pixel hit, track t, when in SCROLL and both hold:
  - `x` ≤ `pixel_x` < `x`+NOTE_W
  - y0 ≤ `pixel_y` < y0+NOTE_H, where y0 = STAFF_Y0 + `pitch`*PITCH_SP
- Comparisons use 11-bit unsigned arithmetic; no wrap is allowed.
- In IDLE the track's output is 0.
- Both outputs may be high on the same pixel; the colour multiplexer resolves overlap.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - Outputs: `objetoNotasOn`=0, `objetoNotasOn2`=0, `note_done`=0, `overflow`=0, `full`=0.
  - Internal state: both FSMs IDLE, FIFOs empty, `x`=START_X, `pitch`=0.
- Reset mid-scroll discards all queued and active notes.
- `objetoNotasOn` and `objetoNotasOn2` are registered, one `clk` of latency from `pixel_x`/`pixel_y`. The display pipeline delays its other object enables by one cycle to match.
- `note_done` and `overflow` are registered pulses, asserted the cycle after the causing `frame_tick`/`note_wr` edge.
- A note is visible from the first frame after its load tick. It takes (START_X−END_X)/STEP decrement ticks plus one retire tick: 291 ticks at defaults.

## Configuration
- `NOTE_PAUSE_EN` defined:
  - `pause` port exists.
  - While `pause`=1, `frame_tick` is ignored for scroll, load and retire.
  - Pushes and pixel outputs continue normally.
- Not defined: no `pause` port; every `frame_tick` advances.

## Test plan
- Reset: hold `reset_n`=0 with `note_wr`/`frame_tick` toggling → all outputs 0, `full`=0; release → no output until a push and a tick.
- Push track 0 pitch 3, then `frame_tick`:
  - Next cycle, `pixel_x`=620..635, `pixel_y`=224..231 → `objetoNotasOn`=1 one cycle later.
  - `pixel_x`=636 → 0.
  - `objetoNotasOn2` stays 0.
- Scroll and retire:
  - After load, 290 ticks → `x`=40, note still visible.
  - Tick 291 → `note_done`=2'b01 pulse, FSM IDLE, output 0.
- Queue full:
  - Five pushes to track 1 with no ticks → `full[1]`=1 after the 4th; 5th → `overflow`=2'b10 pulse.
  - Then push plus retire-pop on the same cycle → still full, no overflow.
- Overlap: both tracks pitch 0 loaded on the same tick → pixel (620,200) gives both outputs 1.
- Reset mid-scroll: assert `reset_n`=0 at `x`=400 with 2 queued → after release, the next `frame_tick` loads nothing and outputs stay 0.
